// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit: fetch PC owner with branch redirect, timed flush and
// redirect counter.                                             Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_redirect_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [63:0]      branch_target,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic [63:0]      pc,
  output logic             fetch_req,
  output logic             flush,
  output logic             redirect,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [63:0]      pc_q, pc_d;
  logic             fetch_req_q, fetch_req_d;
  logic             flush_q, flush_d;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic fetch_accept;
  logic target_aligned;

  assign fetch_accept   = fetch_req_q & fetch_ready & ~stall;
  assign target_aligned = (branch_target[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    fetch_req_d = 1'b1;
    flush_d     = flush_q;
    redirect_d  = 1'b0;
    misalign_d  = 1'b0;
    count_d     = count_q;

    if (fetch_accept) begin
      pc_d = pc_q + 64'd4;
    end

    case (state_q)
      ST_RUN: begin
        // Redirect overrides both the stall hold and the fetch increment.
        if (branch_taken && target_aligned) begin
          pc_d       = branch_target;
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          cnt_d      = FLUSH_INIT;
          count_d    = count_q + CNT_ONE;
          state_d    = ST_FLUSH;
        end else if (branch_taken) begin
          misalign_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Branch decisions here come from squashed instructions; ignore them.
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        flush_d = 1'b0;
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= 3'd0;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      fetch_req_q <= fetch_req_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      misalign_q  <= misalign_d;
      count_q     <= count_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_req    = fetch_req_q;
  assign flush        = flush_q;
  assign redirect     = redirect_q;
  assign misalign_err = misalign_q;
  assign taken_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit: directed scoreboard bench for pc_redirect_unit.
//                                                               Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_redirect_unit;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        fetch_ready;
  logic [63:0] pc;
  logic        fetch_req;
  logic        flush;
  logic        redirect;
  logic        misalign_err;
  logic [31:0] taken_count;

  int total;
  int bad;

  typedef struct packed {
    logic [63:0] pc;
    logic        freq;
    logic        fl;
    logic        rd;
    logic        me;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  pc_redirect_unit #(
    .RESET_PC    (64'h0),
    .FLUSH_CYCLES(2),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .fetch_ready  (fetch_ready),
    .pc           (pc),
    .fetch_req    (fetch_req),
    .flush        (flush),
    .redirect     (redirect),
    .misalign_err (misalign_err),
    .taken_count  (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge,
  // then pop and compare once the edge has settled.
  task automatic step(input logic rst, input logic bt, input logic [63:0] tgt,
                      input logic st, input logic fr,
                      input logic [63:0] e_pc, input logic e_freq, input logic e_fl,
                      input logic e_rd, input logic e_me, input logic [31:0] e_cnt,
                      input string tag);
    exp_t e;
    reset         = rst;
    branch_taken  = bt;
    branch_target = tgt;
    stall         = st;
    fetch_ready   = fr;
    sb.push_back('{pc: e_pc, freq: e_freq, fl: e_fl, rd: e_rd, me: e_me, cnt: e_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},        pc,                  e.pc);
    chk({tag, ".fetch_req"}, {63'd0, fetch_req},  {63'd0, e.freq});
    chk({tag, ".flush"},     {63'd0, flush},      {63'd0, e.fl});
    chk({tag, ".redirect"},  {63'd0, redirect},   {63'd0, e.rd});
    chk({tag, ".misalign"},  {63'd0, misalign_err}, {63'd0, e.me});
    chk({tag, ".count"},     {32'd0, taken_count}, {32'd0, e.cnt});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    stall = 1'b0; fetch_ready = 1'b0;

    // reset state
    step(0, 0, 64'h0,   0, 1, 64'h0,   0, 0, 0, 0, 0, "rst0");
    step(0, 0, 64'h0,   0, 1, 64'h0,   0, 0, 0, 0, 0, "rst1");
    // release: fetch_req rises, then sequential fetch
    step(1, 0, 64'h0,   0, 1, 64'h0,   1, 0, 0, 0, 0, "seq0");
    step(1, 0, 64'h0,   0, 1, 64'h4,   1, 0, 0, 0, 0, "seq4");
    step(1, 0, 64'h0,   0, 1, 64'h8,   1, 0, 0, 0, 0, "seq8");
    step(1, 0, 64'h0,   0, 1, 64'hC,   1, 0, 0, 0, 0, "seqC");
    step(1, 0, 64'h0,   0, 1, 64'h10,  1, 0, 0, 0, 0, "seq10");
    // taken branch to 0x100, flush two cycles
    step(1, 1, 64'h100, 0, 1, 64'h100, 1, 1, 1, 0, 1, "br100");
    step(1, 0, 64'h0,   0, 1, 64'h104, 1, 1, 0, 0, 1, "fl1");
    step(1, 0, 64'h0,   0, 1, 64'h108, 1, 0, 0, 0, 1, "fl_end");
    step(1, 0, 64'h0,   0, 1, 64'h10C, 1, 0, 0, 0, 1, "run10C");
    // redirect beats stall and not-ready; branch in flush is ignored
    step(1, 1, 64'h200, 1, 0, 64'h200, 1, 1, 1, 0, 2, "br200_stall");
    step(1, 1, 64'h300, 0, 1, 64'h204, 1, 1, 0, 0, 2, "ign300");
    step(1, 0, 64'h0,   0, 1, 64'h208, 1, 0, 0, 0, 2, "fl_end2");
    // misaligned targets
    step(1, 1, 64'h102, 0, 1, 64'h20C, 1, 0, 0, 1, 2, "mis102");
    step(1, 0, 64'h0,   0, 1, 64'h210, 1, 0, 0, 0, 2, "mis_clr");
    step(1, 1, 64'h103, 1, 1, 64'h210, 1, 0, 0, 1, 2, "mis103_stall");
    // redirect near top of address space; stall during flush still counts down
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1, 1, 0, 3, "brtop");
    step(1, 0, 64'h0,   1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1, 0, 0, 3, "fl_stall");
    step(1, 0, 64'h0,   0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 3, "fl_end3");
    step(1, 0, 64'h0,   0, 1, 64'h0,   1, 0, 0, 0, 3, "wrap");
    // stall and not-ready holds
    step(1, 0, 64'h0,   1, 1, 64'h0,   1, 0, 0, 0, 3, "stall1");
    step(1, 0, 64'h0,   1, 1, 64'h0,   1, 0, 0, 0, 3, "stall2");
    step(1, 0, 64'h0,   1, 1, 64'h0,   1, 0, 0, 0, 3, "stall3");
    step(1, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 3, "nrdy1");
    step(1, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 3, "nrdy2");
    step(1, 0, 64'h0,   0, 1, 64'h4,   1, 0, 0, 0, 3, "resume");
    // reset during the first flush cycle
    step(1, 1, 64'h400, 0, 1, 64'h400, 1, 1, 1, 0, 4, "br400");
    step(0, 0, 64'h0,   0, 1, 64'h0,   0, 0, 0, 0, 0, "rst_mid");
    step(1, 0, 64'h0,   0, 1, 64'h0,   1, 0, 0, 0, 0, "rel2");
    step(1, 0, 64'h0,   0, 1, 64'h4,   1, 0, 0, 0, 0, "rel2_4");
    // state is RUN again after reset: a fresh redirect is accepted
    step(1, 1, 64'h500, 0, 1, 64'h500, 1, 1, 1, 0, 1, "br500");
    step(1, 0, 64'h0,   0, 1, 64'h504, 1, 1, 0, 0, 1, "fl500");
    step(1, 0, 64'h0,   0, 1, 64'h508, 1, 0, 0, 0, 1, "fl500_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
